// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, idle-high line.
// The pin is synchronised through three flops. A falling edge starts a frame,
// the start bit is re-checked at mid-bit, and data and stop bits are sampled at
// the middle of each bit. A good frame updates uart_rx_data with a one-cycle
// done strobe, and a low stop bit gives a one-cycle ferr strobe.
// Optional build macro UART_RX_PARITY_EN adds a parity bit between the data
// bits and the stop bit, with the sense set by PARITY_ODD. Without the macro
// there is no parity bit and uart_rx_perr is held low.
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned UART_BPS   = 115200,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_rx_busy,
  output logic       uart_rx_ferr,
  output logic       uart_rx_perr
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned HALF_CNT     = BAUD_CNT_MAX / 2;
  localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_CNT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t      state, state_next;
  logic        rxd_d0, rxd_d1, rxd_d2;
  logic        rx_fall, rx_bit;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        bit_end, stop_end;
  logic        frame_ok, frame_ferr;
`ifdef UART_RX_PARITY_EN
  logic        par_err;
  logic        frame_perr;
`endif

  assign rx_fall      = rxd_d2 & ~rxd_d1;
  assign rx_bit       = rxd_d1;
  assign bit_end      = (baud_cnt == BAUD_LAST);
  assign uart_rx_busy = (state != IDLE);

  // Pin synchroniser; reset to idle-high so reset release cannot look like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {rxd_d2, rxd_d1, rxd_d0} <= '1;
    else     {rxd_d2, rxd_d1, rxd_d0} <= {rxd_d1, rxd_d0, uart_rxd};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and end-of-frame classification
  always_comb begin
    state_next = state;
    stop_end   = 1'b0;
    case (state)
      IDLE:  if (rx_fall) state_next = START;
      START: if (baud_cnt == HALF_LAST) state_next = rx_bit ? IDLE : DATA;
      DATA: if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
        state_next = PARITY;
`else
        state_next = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) state_next = STOP;
`endif
      STOP: if (bit_end) begin
        state_next = IDLE;
        stop_end   = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    frame_ferr = stop_end & ~rx_bit;
`ifdef UART_RX_PARITY_EN
    frame_ok   = stop_end & rx_bit & ~par_err;
    frame_perr = stop_end & rx_bit & par_err;
`else
    frame_ok   = stop_end & rx_bit;
`endif
  end

  // Bit timing and data shift; counter restarts on every state change and bit boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (state == IDLE || state_next != state || bit_end) baud_cnt <= '0;
      else                                                 baud_cnt <= baud_cnt + 16'd1;
      if (state == START) begin
        bit_cnt <= '0;
      end else if (state == DATA && bit_end) begin
        shift_reg[bit_cnt] <= rx_bit;
        bit_cnt            <= bit_cnt + 3'd1;
      end
    end
  end

  // Result register and one-cycle status strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_rx_data <= '0;
      uart_rx_done <= 1'b0;
      uart_rx_ferr <= 1'b0;
    end else begin
      uart_rx_done <= frame_ok;
      uart_rx_ferr <= frame_ferr;
      if (frame_ok) uart_rx_data <= shift_reg;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity check result is carried to the stop bit, where ferr outranks perr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err      <= 1'b0;
      uart_rx_perr <= 1'b0;
    end else begin
      uart_rx_perr <= frame_perr;
      if (state == START)                 par_err <= 1'b0;
      else if (state == PARITY && bit_end) par_err <= rx_bit ^ (^shift_reg) ^ PARITY_ODD;
    end
  end
`else
  // Parity sense has no effect without a parity bit; the error output stays low
  assign uart_rx_perr = PARITY_ODD & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a frame-level reference
// model. Each sent frame yields one expected event (cycle, kind, data); a monitor
// records observed strobes and the two lists are compared per scenario.
// Honours UART_RX_PARITY_EN to match the DUT build.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned BIT  = 434;
  localparam int unsigned HALF = 217;
  localparam bit          P_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS   = 10;
  localparam bit          USE_PAR = 1'b1;
`else
  localparam int unsigned NBITS   = 9;
  localparam bit          USE_PAR = 1'b0;
`endif
  // pin edge -> first START cycle is three synchroniser cycles
  localparam int unsigned DONE_LAT = 3 + HALF + NBITS * BIT;

  localparam int unsigned EV_DONE = 0, EV_FERR = 1, EV_PERR = 2;

  typedef struct {
    int unsigned cyc;
    int unsigned kind;
    logic [7:0]  data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic [7:0] uart_rx_data;
  logic       uart_rx_done, uart_rx_busy, uart_rx_ferr, uart_rx_perr;

  int unsigned n_tests, n_fail;
  int unsigned cyc = 0;
  logic [7:0]  model_data;
  ev_t         got_q[$];
  ev_t         exp_q[$];

  uart_rx #(
    .CLK_FREQ  (50000000),
    .UART_BPS  (115200),
    .PARITY_ODD(P_ODD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rxd    (uart_rxd),
    .uart_rx_data(uart_rx_data),
    .uart_rx_done(uart_rx_done),
    .uart_rx_busy(uart_rx_busy),
    .uart_rx_ferr(uart_rx_ferr),
    .uart_rx_perr(uart_rx_perr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record every status strobe with the cycle it appeared in
  always @(negedge clk) begin
    if (rst === 1'b0 && (uart_rx_done | uart_rx_ferr | uart_rx_perr)) begin
      int s;
      s = int'(uart_rx_done) + int'(uart_rx_ferr) + int'(uart_rx_perr);
      check("one_pulse", s, 1);
      if (uart_rx_done) got_q.push_back('{cyc, EV_DONE, uart_rx_data});
      if (uart_rx_ferr) got_q.push_back('{cyc, EV_FERR, uart_rx_data});
      if (uart_rx_perr) got_q.push_back('{cyc, EV_PERR, uart_rx_data});
    end
  end

  task automatic drive(input logic v, input int unsigned n);
    uart_rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send one frame and predict its single outcome from the frame rules
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip);
    int unsigned k;
    k = cyc;
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
`ifdef UART_RX_PARITY_EN
    begin
      logic p;
      p = (^b) ^ P_ODD ^ par_flip;
      drive(p, BIT);
    end
`endif
    drive(stop_ok, BIT);
    if (!stop_ok) begin
      exp_q.push_back('{k + DONE_LAT, EV_FERR, model_data});
      drive(1'b1, BIT);
    end else if (USE_PAR && par_flip) begin
      exp_q.push_back('{k + DONE_LAT, EV_PERR, model_data});
    end else begin
      model_data = b;
      exp_q.push_back('{k + DONE_LAT, EV_DONE, b});
    end
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_cyc"},  got_q[i].cyc,  exp_q[i].cyc);
      check({tag, "_kind"}, got_q[i].kind, exp_q[i].kind);
      check({tag, "_data"}, got_q[i].data, exp_q[i].data);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit ok, flip;
    n_tests = 0;
    n_fail = 0;
    model_data = 8'h00;
    uart_rxd = 1'b1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_data", uart_rx_data, 8'h00);
    check("rst_done", uart_rx_done, 1'b0);
    check("rst_busy", uart_rx_busy, 1'b0);
    check("rst_ferr", uart_rx_ferr, 1'b0);
    check("rst_perr", uart_rx_perr, 1'b0);
    rst = 1'b0;

    drive(1'b1, 20000);
    compare_events("idle");
    check("idle_busy", uart_rx_busy, 1'b0);
    check("idle_data", uart_rx_data, 8'h00);

    send_frame(8'h55, 1'b1, 1'b0);
    compare_events("f55");
    check("f55_busy", uart_rx_busy, 1'b0);
    check("f55_data", uart_rx_data, 8'h55);

    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    compare_events("b2b");
    drive(1'b1, 50);

    // 100-cycle glitch: START is abandoned at the half-bit check
    drive(1'b0, 100);
    drive(1'b1, 119);
    check("glitch_busy_hi", uart_rx_busy, 1'b1);
    drive(1'b1, 1);
    check("glitch_busy_lo", uart_rx_busy, 1'b0);
    drive(1'b1, 100);
    compare_events("glitch");
    send_frame(8'h3C, 1'b1, 1'b0);
    compare_events("f3c");

    send_frame(8'h81, 1'b0, 1'b0);
    compare_events("ferr");
    check("ferr_data_kept", uart_rx_data, 8'h3C);
    send_frame(8'h81, 1'b1, 1'b0);
    compare_events("f81");

    // Reset in the middle of bit 4 of 0x7E
    b = 8'h7E;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(b[i], BIT);
    drive(b[4], HALF);
    rst = 1'b1;
    drive(1'b1, 2);
    rst = 1'b0;
    model_data = 8'h00;
    check("midrst_data", uart_rx_data, 8'h00);
    check("midrst_busy", uart_rx_busy, 1'b0);
    drive(1'b1, BIT);
    compare_events("midrst");
    send_frame(8'h7E, 1'b1, 1'b0);
    compare_events("f7e");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    compare_events("parity");
`endif

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      flip = USE_PAR && ($urandom_range(0, 1) == 1);
      send_frame(b, ok, flip);
      drive(1'b1, $urandom_range(0, 1) == 0 ? 1 : $urandom_range(1, 300));
    end
    compare_events("rand");
    check("final_data", uart_rx_data, model_data);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
